alu_cmd_seq: RTL

Operand/command entry sequencer that sits directly upstream of the 4-bit ALU. It steps through A, B and opcode entry, taking one value per debounced button press from the 4-bit switch bank, and presents registered `a`, `b` and `ctrl` to the ALU. It then captures the ALU's combinational `res`/`car`/`of` into a result register for display.

---
 rtl/alu_cmd_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - operand/opcode entry sequencer feeding a 4-bit ALU
// Button synchronizer/debouncer plus a five-state load/exec/show FSM.

module alu_cmd_seq_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_btn_s1;
  logic          r_btn_s;
  logic          r_btn_db;
  logic          r_btn_db_d;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // Level must disagree with the debounced value for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1   <= 1'b0;
      r_btn_s    <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_cnt      <= '0;
      r_press    <= 1'b0;
    end else begin
      r_btn_s1   <= i_btn;
      r_btn_s    <= r_btn_s1;
      if (r_btn_s != r_btn_db) begin
        if (r_cnt == CNT_MAX) begin
          r_btn_db <= r_btn_s;
          r_cnt    <= '0;
        end else begin
          r_cnt    <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
      r_btn_db_d <= r_btn_db;
      r_press    <= r_btn_db & ~r_btn_db_d;
    end
  end

  assign o_press = r_press;

endmodule

module alu_cmd_seq #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn,
  input  logic [3:0] res_in,
  input  logic       car_in,
  input  logic       of_in,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] ctrl,
  output logic       op_valid,
  output logic [3:0] res_q,
  output logic       car_q,
  output logic       of_q,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [2:0] S_LOAD_A  = 3'd0;
  localparam logic [2:0] S_LOAD_B  = 3'd1;
  localparam logic [2:0] S_LOAD_OP = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_SHOW    = 3'd4;

  logic       w_press;
  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_load_a;
  logic       w_load_b;
  logic       w_load_op;
  logic       w_capture;
  logic       w_op_valid;
  logic       w_done;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [2:0] r_ctrl;
  logic [3:0] r_res;
  logic       r_car;
  logic       r_of;

  alu_cmd_seq_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn),
    .o_press(w_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD_A;
    end else begin
      r_state <= w_next;
    end
  end

  // Codes 5-7 fall into the default arm and recover to LOAD_A.
  always_comb begin
    w_next = S_LOAD_A;
    case (r_state)
      S_LOAD_A:  w_next = w_press ? S_LOAD_B  : S_LOAD_A;
      S_LOAD_B:  w_next = w_press ? S_LOAD_OP : S_LOAD_B;
      S_LOAD_OP: w_next = w_press ? S_EXEC    : S_LOAD_OP;
      S_EXEC:    w_next = S_SHOW;
      S_SHOW:    w_next = w_press ? S_LOAD_A  : S_SHOW;
      default:   w_next = S_LOAD_A;
    endcase
  end

  always_comb begin
    w_load_a   = 1'b0;
    w_load_b   = 1'b0;
    w_load_op  = 1'b0;
    w_capture  = 1'b0;
    w_op_valid = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_LOAD_A:  w_load_a  = w_press;
      S_LOAD_B:  w_load_b  = w_press;
      S_LOAD_OP: w_load_op = w_press;
      S_EXEC: begin
        w_op_valid = 1'b1;
        w_capture  = 1'b1;
      end
      S_SHOW:    w_done    = 1'b1;
      default:   w_done    = 1'b0;
    endcase
  end

  // Operands only move on their own load edge so the ALU is settled through EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= 4'h0;
      r_b    <= 4'h0;
      r_ctrl <= 3'h0;
      r_res  <= 4'h0;
      r_car  <= 1'b0;
      r_of   <= 1'b0;
    end else begin
      if (w_load_a) begin
        r_a <= sw;
      end
      if (w_load_b) begin
        r_b <= sw;
      end
      if (w_load_op) begin
        r_ctrl <= sw[2:0];
      end
      if (w_capture) begin
        r_res <= res_in;
        r_car <= car_in;
        r_of  <= of_in;
      end
    end
  end

  assign a        = r_a;
  assign b        = r_b;
  assign ctrl     = r_ctrl;
  assign res_q    = r_res;
  assign car_q    = r_car;
  assign of_q     = r_of;
  assign op_valid = w_op_valid;
  assign done     = w_done;
  assign state    = r_state;

endmodule
